// File: rtl/conv_scheduler_if.sv
// Handshake and converter-side bus between two requesters and the conv_scheduler.
// master: requester/bench side; slave: the scheduler.
interface conv_scheduler_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic [31:0] word_out;
  logic [1:0]  pclk;
  logic        enb;
  logic [1:0]  grant;
  logic        busy;

  modport master (
    output req0_valid, req0_data, req0_mode, req1_valid, req1_data, req1_mode,
    input  req0_ready, req1_ready, word_out, pclk, enb, grant, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_mode, req1_valid, req1_data, req1_mode,
    output req0_ready, req1_ready, word_out, pclk, enb, grant, busy
  );
endinterface

// File: rtl/conv_scheduler.sv
// Two-requester scheduler feeding a 32-to-8 converter; READY is combinational, outputs registered.
// Macro CONV_SCHED_RR_EN: round-robin with MAX_BURST cap; undefined: fixed priority to requester 0.
module conv_scheduler #(
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset_l,
  conv_scheduler_if.slave bus
);

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [3:0]  burst_cnt;
  logic        last_owner;
  logic [31:0] word_q;
  logic [1:0]  pclk_q;
  logic        enb_q;
  logic [1:0]  grant_q;
  logic        busy_q;
  logic        can_accept;
  logic        win0;
  logic        win1;
  logic        xfer;
  logic [31:0] xfer_data;
  logic [1:0]  xfer_mode;
`ifdef CONV_SCHED_RR_EN
  logic        rr_ptr;
`endif

  function automatic logic [1:0] last_idx(input logic [1:0] mode);
    case (mode)
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd0;
      default: last_idx = 2'd3;
    endcase
  endfunction

  // Gated by reset so no READY strobe can leak out while the block is held in reset.
  assign can_accept = reset_l && ((state == IDLE) || (byte_cnt == 2'd0));

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
`ifdef CONV_SCHED_RR_EN
    if (bus.req0_valid && bus.req1_valid) begin
      if (burst_cnt >= BURST_CAP) begin
        win0 = last_owner;
        win1 = !last_owner;
      end else begin
        win0 = !rr_ptr;
        win1 = rr_ptr;
      end
    end else begin
      win0 = bus.req0_valid;
      win1 = bus.req1_valid;
    end
`else
    win0 = bus.req0_valid;
    win1 = bus.req1_valid && !bus.req0_valid;
`endif
  end

  assign xfer           = can_accept && (win0 || win1);
  assign xfer_data      = win1 ? bus.req1_data : bus.req0_data;
  assign xfer_mode      = win1 ? bus.req1_mode : bus.req0_mode;
  assign bus.req0_ready = can_accept && win0;
  assign bus.req1_ready = can_accept && win1;
  assign bus.word_out   = word_q;
  assign bus.pclk       = pclk_q;
  assign bus.enb        = enb_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      burst_cnt  <= 4'd0;
      last_owner <= 1'b0;
      word_q     <= 32'd0;
      pclk_q     <= 2'b00;
      enb_q      <= 1'b0;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
`ifdef CONV_SCHED_RR_EN
      rr_ptr     <= 1'b0;
`endif
    end else if (xfer) begin
      state      <= SEND;
      byte_cnt   <= last_idx(xfer_mode);
      word_q     <= xfer_data;
      pclk_q     <= xfer_mode;
      enb_q      <= 1'b1;
      grant_q    <= win1 ? 2'b10 : 2'b01;
      busy_q     <= 1'b1;
      last_owner <= win1;
      if (win1 != last_owner)
        burst_cnt <= 4'd1;
      else if (burst_cnt < BURST_CAP)
        burst_cnt <= burst_cnt + 4'd1;
`ifdef CONV_SCHED_RR_EN
      rr_ptr     <= !win1;
`endif
    end else if (state == SEND) begin
      if (byte_cnt != 2'd0) begin
        byte_cnt <= byte_cnt - 2'd1;
      end else begin
        // Word drained with nobody ready to follow: WORD_OUT/PCLK keep their values.
        state   <= IDLE;
        enb_q   <= 1'b0;
        grant_q <= 2'b00;
        busy_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler; expectations adapt to CONV_SCHED_RR_EN, MAX_BURST fixed at 2.
module tb_conv_scheduler;

`ifdef CONV_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset_l;
  int   checks = 0;
  int   errors = 0;

  conv_scheduler_if bus ();

  conv_scheduler #(.MAX_BURST(2)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_l        = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 32'd0;
    bus.req0_mode  = 2'b00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 32'd0;
    bus.req1_mode  = 2'b00;
    repeat (2) tick();

    // Reset state; READY must stay low even with a valid requester.
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_word",  bus.word_out, 32'd0);
    chk("rst_pclk",  32'(bus.pclk), 32'd0);
    chk("rst_enb",   32'(bus.enb), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
    bus.req0_valid = 1'b0;
    tick();
    reset_l = 1'b1;

    // Single mode-00 word from requester 0; requester 1 pulses valid mid-word only.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hA1B2C3D4;
    bus.req0_mode  = 2'b00;
    #1;
    chk("w0_rdy0_idle", 32'(bus.req0_ready), 32'd1);
    chk("w0_rdy1_idle", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'hDEADBEEF;
    #1;
    chk("w0_c1_enb",   32'(bus.enb), 32'd1);
    chk("w0_c1_grant", 32'(bus.grant), 32'd1);
    chk("w0_c1_pclk",  32'(bus.pclk), 32'd0);
    chk("w0_c1_word",  bus.word_out, 32'hA1B2C3D4);
    chk("w0_c1_busy",  32'(bus.busy), 32'd1);
    chk("w0_c1_rdy1",  32'(bus.req1_ready), 32'd0);
    tick();
    chk("w0_c2_rdy1",  32'(bus.req1_ready), 32'd0);
    chk("w0_c2_enb",   32'(bus.enb), 32'd1);
    bus.req1_valid = 1'b0;
    tick();
    chk("w0_c3_grant", 32'(bus.grant), 32'd1);
    tick();
    chk("w0_c4_enb",   32'(bus.enb), 32'd1);
    chk("w0_c4_grant", 32'(bus.grant), 32'd1);
    tick();
    chk("w0_end_enb",   32'(bus.enb), 32'd0);
    chk("w0_end_grant", 32'(bus.grant), 32'd0);
    chk("w0_end_busy",  32'(bus.busy), 32'd0);
    chk("w0_end_word",  bus.word_out, 32'hA1B2C3D4);

    // Requester 1 streams modes 01, 10, 11 back to back: seven ENB cycles.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h11111111;
    bus.req1_mode  = 2'b01;
    #1;
    chk("s1_c0_rdy1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_data = 32'h22222222;
    bus.req1_mode = 2'b10;
    #1;
    chk("s1_c1_enb",   32'(bus.enb), 32'd1);
    chk("s1_c1_grant", 32'(bus.grant), 32'd2);
    chk("s1_c1_pclk",  32'(bus.pclk), 32'd1);
    chk("s1_c1_word",  bus.word_out, 32'h11111111);
    chk("s1_c1_rdy1",  32'(bus.req1_ready), 32'd0);
    tick();
    chk("s1_c2_enb",  32'(bus.enb), 32'd1);
    chk("s1_c2_rdy1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_data = 32'h33333333;
    bus.req1_mode = 2'b11;
    #1;
    chk("s1_c3_enb",  32'(bus.enb), 32'd1);
    chk("s1_c3_pclk", 32'(bus.pclk), 32'd2);
    chk("s1_c3_word", bus.word_out, 32'h22222222);
    chk("s1_c3_rdy1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("s1_c4_enb",  32'(bus.enb), 32'd1);
    chk("s1_c4_pclk", 32'(bus.pclk), 32'd3);
    chk("s1_c4_word", bus.word_out, 32'h33333333);
    for (int i = 5; i <= 7; i++) begin
      tick();
      chk($sformatf("s1_c%0d_enb", i), 32'(bus.enb), 32'd1);
    end
    tick();
    chk("s1_c8_enb",   32'(bus.enb), 32'd0);
    chk("s1_c8_grant", 32'(bus.grant), 32'd0);

    // Both requesters valid, single-byte words.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h0A0A0A0A;
    bus.req0_mode  = 2'b10;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h0B0B0B0B;
    bus.req1_mode  = 2'b10;
    #1;
    chk("both_idle_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("both_idle_rdy1", 32'(bus.req1_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic odd;
      odd = (i % 2) == 1;
      tick();
      chk($sformatf("both_%0d_grant", i), 32'(bus.grant), (RR && odd) ? 32'd2 : 32'd1);
      chk($sformatf("both_%0d_word", i), bus.word_out, (RR && odd) ? 32'h0B0B0B0B : 32'h0A0A0A0A);
      chk($sformatf("both_%0d_rdy1", i), 32'(bus.req1_ready), (RR && !odd) ? 32'd1 : 32'd0);
      chk($sformatf("both_%0d_rdy0", i), 32'(bus.req0_ready), (RR && !odd) ? 32'd0 : 32'd1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("both_end_enb", 32'(bus.enb), 32'd0);

    // Burst cap 2: requester 0 streams, requester 1 joins during its second word.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h55AA55AA;
    bus.req0_mode  = 2'b01;
    #1;
    chk("bur_c0_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    chk("bur_c1_grant", 32'(bus.grant), 32'd1);
    chk("bur_c1_rdy0",  32'(bus.req0_ready), 32'd0);
    tick();
    chk("bur_c2_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'hCAFEF00D;
    bus.req1_mode  = 2'b10;
    #1;
    chk("bur_c3_grant", 32'(bus.grant), 32'd1);
    chk("bur_c3_rdy1",  32'(bus.req1_ready), 32'd0);
    tick();
    chk("bur_c4_rdy1", 32'(bus.req1_ready), RR ? 32'd1 : 32'd0);
    chk("bur_c4_rdy0", 32'(bus.req0_ready), RR ? 32'd0 : 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("bur_c5_grant", 32'(bus.grant), RR ? 32'd2 : 32'd1);
    chk("bur_c5_word",  bus.word_out, RR ? 32'hCAFEF00D : 32'h55AA55AA);
    chk("bur_c5_pclk",  32'(bus.pclk), RR ? 32'd2 : 32'd1);
    chk("bur_c5_rdy0",  32'(bus.req0_ready), RR ? 32'd1 : 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("bur_c6_grant", 32'(bus.grant), 32'd1);
    for (int k = 0; k < 8 && bus.enb; k++) tick();
    chk("bur_drain_enb", 32'(bus.enb), 32'd0);

    // Reset in the second cycle of a mode-00 word.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h12345678;
    bus.req0_mode  = 2'b00;
    #1;
    chk("ra_c0_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    chk("ra_c1_enb",  32'(bus.enb), 32'd1);
    chk("ra_c1_word", bus.word_out, 32'h12345678);
    tick();
    reset_l = 1'b0;
    #1;
    chk("ra_enb",   32'(bus.enb), 32'd0);
    chk("ra_grant", 32'(bus.grant), 32'd0);
    chk("ra_word",  bus.word_out, 32'd0);
    chk("ra_pclk",  32'(bus.pclk), 32'd0);
    chk("ra_busy",  32'(bus.busy), 32'd0);
    chk("ra_rdy0",  32'(bus.req0_ready), 32'd0);
    bus.req0_valid = 1'b0;
    tick();

    // First transfer on the first edge after release.
    reset_l        = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h0F0F0F0F;
    bus.req1_mode  = 2'b10;
    #1;
    chk("rel_rdy1", 32'(bus.req1_ready), 32'd1);
    chk("rel_enb",  32'(bus.enb), 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("rel_c1_enb",   32'(bus.enb), 32'd1);
    chk("rel_c1_grant", 32'(bus.grant), 32'd2);
    chk("rel_c1_word",  bus.word_out, 32'h0F0F0F0F);
    tick();
    chk("rel_end_enb",  32'(bus.enb), 32'd0);
    chk("rel_end_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
